// File: rtl/fan_packet_tx.sv
// OOK transmitter for a fan remote. Each frame is a sync symbol, 18 pulse-width
// coded bits (address then command code), and a low tail.
module fan_packet_tx #(
    parameter int          SYM_DIV   = 1000,
    parameter int          TAIL_SYMS = 20,
    parameter logic [11:0] ADDR      = 12'h5A3
) (
    input  logic       ref_clk,
    input  logic       reset,
    input  logic       start_packet,
    input  logic [2:0] cmd,
    output logic       rf_out,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        TAIL = 2'd3
    } state_t;

    localparam logic [15:0] SYM_LAST  = 16'(SYM_DIV - 1);
    localparam logic [7:0]  TAIL_LAST = 8'(TAIL_SYMS - 1);
    localparam logic [4:0]  BIT_LAST  = 5'd17;
    localparam logic [1:0]  SLOT_LAST = 2'd2;

    state_t      state;
    state_t      state_n;
    logic [15:0] sym_cnt;
    logic [15:0] sym_cnt_n;
    logic [1:0]  slot_cnt;
    logic [1:0]  slot_cnt_n;
    logic [4:0]  bit_idx;
    logic [4:0]  bit_idx_n;
    logic [7:0]  tail_cnt;
    logic [7:0]  tail_cnt_n;
    logic [5:0]  code;
    logic [5:0]  code_n;
    logic [5:0]  cmd_code;
    logic        cmd_valid;
    logic        sym_end;
    logic [17:0] frame_bits_n;
    logic        rf_out_n;
    logic        busy_n;

    // Command decode; codes 5..7 have no mapping and never start a frame.
    always_comb begin
        cmd_code  = 6'h00;
        cmd_valid = 1'b1;
        case (cmd)
            3'd0:    cmd_code = 6'h01;
            3'd1:    cmd_code = 6'h02;
            3'd2:    cmd_code = 6'h04;
            3'd3:    cmd_code = 6'h08;
            3'd4:    cmd_code = 6'h10;
            default: cmd_valid = 1'b0;
        endcase
    end

    assign sym_end = (sym_cnt == SYM_LAST);

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state    <= IDLE;
            sym_cnt  <= '0;
            slot_cnt <= '0;
            bit_idx  <= '0;
            tail_cnt <= '0;
            code     <= '0;
            rf_out   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            sym_cnt  <= sym_cnt_n;
            slot_cnt <= slot_cnt_n;
            bit_idx  <= bit_idx_n;
            tail_cnt <= tail_cnt_n;
            code     <= code_n;
            rf_out   <= rf_out_n;
            busy     <= busy_n;
        end
    end

    // Next-state and counter update; the symbol counter free-runs outside IDLE
    // and every coarser counter advances only on its wrap.
    always_comb begin
        state_n    = state;
        sym_cnt_n  = sym_cnt;
        slot_cnt_n = slot_cnt;
        bit_idx_n  = bit_idx;
        tail_cnt_n = tail_cnt;
        code_n     = code;

        case (state)
            IDLE: begin
                sym_cnt_n  = '0;
                slot_cnt_n = '0;
                bit_idx_n  = '0;
                tail_cnt_n = '0;
                if (start_packet && cmd_valid) begin
                    state_n = SYNC;
                    code_n  = cmd_code;
                end
            end
            SYNC: begin
                if (sym_end) begin
                    state_n    = DATA;
                    sym_cnt_n  = '0;
                    slot_cnt_n = '0;
                    bit_idx_n  = '0;
                end else begin
                    sym_cnt_n = sym_cnt + 16'd1;
                end
            end
            DATA: begin
                if (sym_end) begin
                    sym_cnt_n = '0;
                    if (slot_cnt >= SLOT_LAST) begin
                        slot_cnt_n = '0;
                        if (bit_idx >= BIT_LAST) begin
                            state_n    = TAIL;
                            bit_idx_n  = '0;
                            tail_cnt_n = '0;
                        end else begin
                            bit_idx_n = bit_idx + 5'd1;
                        end
                    end else begin
                        slot_cnt_n = slot_cnt + 2'd1;
                    end
                end else begin
                    sym_cnt_n = sym_cnt + 16'd1;
                end
            end
            TAIL: begin
                if (sym_end) begin
                    sym_cnt_n = '0;
                    if (tail_cnt >= TAIL_LAST) begin
                        state_n    = IDLE;
                        tail_cnt_n = '0;
                    end else begin
                        tail_cnt_n = tail_cnt + 8'd1;
                    end
                end else begin
                    sym_cnt_n = sym_cnt + 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are derived from the next-cycle values so they can be registered
    // without adding a cycle of latency after acceptance.
    always_comb begin
        frame_bits_n = {ADDR, code_n};
        rf_out_n     = 1'b0;
        busy_n       = (state_n != IDLE);
        case (state_n)
            SYNC: rf_out_n = 1'b1;
            DATA: begin
                case (slot_cnt_n)
                    2'd0:    rf_out_n = 1'b1;
                    2'd1:    rf_out_n = frame_bits_n[BIT_LAST - bit_idx_n];
                    default: rf_out_n = 1'b0;
                endcase
            end
            default: rf_out_n = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_fan_packet_tx.sv
// Self-checking bench for fan_packet_tx: a symbol-level frame model is compared
// against the captured rf_out waveform for directed and random commands.
module tb_fan_packet_tx;

    localparam int          SYM_DIV   = 4;
    localparam int          TAIL_SYMS = 2;
    localparam logic [11:0] ADDR      = 12'hA5C;
    localparam int          FRAME     = SYM_DIV * (55 + TAIL_SYMS);

    logic       ref_clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_packet = 1'b0;
    logic [2:0] cmd = 3'd0;
    logic       rf_out;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [FRAME-1:0] wave;
    int               busy_low;

    fan_packet_tx #(
        .SYM_DIV  (SYM_DIV),
        .TAIL_SYMS(TAIL_SYMS),
        .ADDR     (ADDR)
    ) dut (
        .ref_clk     (ref_clk),
        .reset       (reset),
        .start_packet(start_packet),
        .cmd         (cmd),
        .rf_out      (rf_out),
        .busy        (busy)
    );

    always #5 ref_clk = ~ref_clk;

    // ---------------- reference model ----------------
    function automatic logic [5:0] model_code(input int c);
        return 6'(1 << c);
    endfunction

    function automatic logic [FRAME-1:0] model_wave(input logic [5:0] code);
        logic             syms[$];
        logic [17:0]      bits;
        logic [FRAME-1:0] w;
        bits = {ADDR, code};
        syms.push_back(1'b1);
        for (int i = 17; i >= 0; i--) begin
            syms.push_back(1'b1);
            syms.push_back(bits[i]);
            syms.push_back(1'b0);
        end
        for (int i = 0; i < TAIL_SYMS; i++) syms.push_back(1'b0);
        w = '0;
        for (int s = 0; s < syms.size(); s++)
            for (int j = 0; j < SYM_DIV; j++) w[s*SYM_DIV+j] = syms[s];
        return w;
    endfunction

    // Reads the middle symbol of each 3-symbol bit slot.
    function automatic logic [17:0] decode(input logic [FRAME-1:0] w);
        logic [17:0] d;
        for (int i = 0; i < 18; i++) d[17-i] = w[(2 + 3*i)*SYM_DIV + SYM_DIV/2];
        return d;
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic start_frame(input logic [2:0] c);
        start_packet = 1'b1;
        cmd          = c;
        step();
        start_packet = 1'b0;
    endtask

    // Records FRAME cycles starting with the first cycle after acceptance, then
    // steps once more so the caller sits on the first cycle after the frame.
    task automatic capture(input int inject_at, input logic [2:0] inject_cmd, input bit noise);
        busy_low = 0;
        for (int k = 0; k < FRAME; k++) begin
            wave[k] = rf_out;
            if (busy !== 1'b1) busy_low++;
            if (noise) begin
                cmd          = 3'($urandom_range(0, 7));
                start_packet = ($urandom_range(0, 3) == 0);
            end else begin
                start_packet = (k == inject_at);
                if (k == inject_at) cmd = inject_cmd;
            end
            step();
        end
        start_packet = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset        = 1'b1;
        start_packet = 1'b1;
        cmd          = 3'd2;
        repeat (3) step();
        tests++;
        if (busy !== 1'b0 || rf_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b rf_out=%b want 0 0", busy, rf_out);
        end
        reset        = 1'b0;
        start_packet = 1'b0;
        step();
        tests++;
        if (busy !== 1'b0 || rf_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_idle: busy=%b rf_out=%b want 0 0", busy, rf_out);
        end
    endtask

    task automatic test_cmd2_frame();
        logic [FRAME-1:0] exp_w;
        start_frame(3'd2);
        capture(-1, 3'd0, 1'b0);
        exp_w = model_wave(6'h04);
        tests++;
        if (busy_low !== 0) begin
            fails++;
            $display("FAIL cmd2_busy: %0d cycles low within frame, want 0", busy_low);
        end
        tests++;
        if (wave[SYM_DIV-1:0] !== {SYM_DIV{1'b1}}) begin
            fails++;
            $display("FAIL cmd2_sync: got %b want all ones", wave[SYM_DIV-1:0]);
        end
        tests++;
        if (decode(wave) !== 18'b101001011100_000100) begin
            fails++;
            $display("FAIL cmd2_bits: got %b want 101001011100000100", decode(wave));
        end
        tests++;
        if (wave[FRAME-1 -: 8] !== 8'h00) begin
            fails++;
            $display("FAIL cmd2_tail: got %b want 00000000", wave[FRAME-1 -: 8]);
        end
        tests++;
        if (wave !== exp_w) begin
            fails++;
            $display("FAIL cmd2_wave: got %h want %h", wave, exp_w);
        end
        tests++;
        if (busy !== 1'b0 || rf_out !== 1'b0) begin
            fails++;
            $display("FAIL cmd2_end: busy=%b rf_out=%b want 0 0", busy, rf_out);
        end
    endtask

    task automatic test_codes();
        logic [2:0]  cmds[2];
        logic [17:0] exp_bits[2];
        cmds[0]     = 3'd4;
        cmds[1]     = 3'd0;
        exp_bits[0] = {ADDR, 6'b010000};
        exp_bits[1] = {ADDR, 6'b000001};
        for (int i = 0; i < 2; i++) begin
            start_frame(cmds[i]);
            capture(-1, 3'd0, 1'b0);
            tests++;
            if (decode(wave) !== exp_bits[i]) begin
                fails++;
                $display("FAIL code_cmd%0d: got %b want %b", cmds[i], decode(wave), exp_bits[i]);
            end
            tests++;
            if (busy_low !== 0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL code_busy_cmd%0d: low_in_frame=%0d busy_after=%b want 0 0",
                         cmds[i], busy_low, busy);
            end
        end
    endtask

    task automatic test_invalid_cmd();
        int highs;
        for (int c = 5; c < 8; c++) begin
            highs = 0;
            start_frame(3'(c));
            for (int k = 0; k < 300; k++) begin
                if (busy !== 1'b0 || rf_out !== 1'b0) highs++;
                step();
            end
            tests++;
            if (highs !== 0) begin
                fails++;
                $display("FAIL invalid_cmd%0d: %0d active cycles want 0", c, highs);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int highs;
        logic [FRAME-1:0] exp_w;
        start_frame(3'd3);
        capture(49, 3'd1, 1'b0);
        exp_w = model_wave(6'h08);
        tests++;
        if (decode(wave) !== {ADDR, 6'b001000}) begin
            fails++;
            $display("FAIL ignore_busy_bits: got %b want %b", decode(wave), {ADDR, 6'b001000});
        end
        tests++;
        if (wave !== exp_w || busy_low !== 0) begin
            fails++;
            $display("FAIL ignore_busy_wave: got %h want %h busy_low=%0d", wave, exp_w, busy_low);
        end
        highs = 0;
        for (int k = 0; k < 300; k++) begin
            if (busy !== 1'b0) highs++;
            step();
        end
        tests++;
        if (highs !== 0) begin
            fails++;
            $display("FAIL ignore_busy_single: %0d busy cycles after frame want 0", highs);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [2:0] c;
        c = 3'($urandom_range(0, 4));
        start_frame(c);
        repeat (99) step();
        reset = 1'b1;
        step();
        tests++;
        if (busy !== 1'b0 || rf_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b rf_out=%b want 0 0", busy, rf_out);
        end
        reset = 1'b0;
        step();
        c = 3'($urandom_range(0, 4));
        start_frame(c);
        capture(-1, 3'd0, 1'b0);
        tests++;
        if (wave !== model_wave(model_code(int'(c))) || busy_low !== 0) begin
            fails++;
            $display("FAIL reset_restart_cmd%0d: got %h want %h busy_low=%0d",
                     c, wave, model_wave(model_code(int'(c))), busy_low);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] c;
        start_frame(3'd1);
        capture(-1, 3'd0, 1'b0);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_gap: busy=%b want 0", busy);
        end
        c = 3'($urandom_range(0, 4));
        start_frame(c);
        capture(-1, 3'd0, 1'b0);
        tests++;
        if (busy_low !== 0 || wave !== model_wave(model_code(int'(c)))) begin
            fails++;
            $display("FAIL b2b_second_cmd%0d: busy_low=%0d got %h want %h",
                     c, busy_low, wave, model_wave(model_code(int'(c))));
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: busy=%b want 0", busy);
        end
    endtask

    // Random commands, gaps, and cmd/start noise during the frame.
    task automatic test_random_frames();
        logic [2:0] c;
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(0, 5)) step();
            c = 3'($urandom_range(0, 4));
            start_frame(c);
            capture(-1, 3'd0, 1'b1);
            tests++;
            if (wave !== model_wave(model_code(int'(c))) || busy_low !== 0) begin
                fails++;
                $display("FAIL random_frame%0d_cmd%0d: got %h want %h busy_low=%0d",
                         n, c, wave, model_wave(model_code(int'(c))), busy_low);
            end
            tests++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL random_end%0d: busy=%b want 0", n, busy);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_cmd2_frame();
        test_codes();
        test_invalid_cmd();
        test_ignore_busy();
        test_reset_mid_frame();
        test_back_to_back();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
